// File: rtl/arm_seq_ctrl_pkg.sv
// Shared definitions for the ARM sequencer: state encoding, PC stepping and alignment.
package arm_seq_ctrl_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned TMR_W = 8;

  localparam logic [XLEN-1:0] PC_STEP    = 32'd4;
  localparam logic [XLEN-1:0] ALIGN_MASK = 32'hFFFF_FFFC;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_HALT   = 3'd3,
    ST_FAULT  = 3'd4
  } seq_state_e;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return addr & ALIGN_MASK;
  endfunction

endpackage

// File: rtl/arm_seq_ctrl_if.sv
// Instruction-memory fetch handshake between the sequencer (master) and memory (slave).
interface arm_seq_ctrl_if;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (output imem_req, output imem_addr, input imem_ack, input imem_rdata);
  modport slave  (input imem_req, input imem_addr, output imem_ack, output imem_rdata);

endinterface

// File: rtl/arm_fetch_timer.sv
// Loadable up-counter; last_c flags the count one below LIMIT so the next enabled tick reaches it.
module arm_fetch_timer
  import arm_seq_ctrl_pkg::*;
#(
  parameter int unsigned LIMIT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [TMR_W-1:0] load_val,
  input  logic             en,
  output logic             last_c
);

  logic [TMR_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en) begin
      cnt <= cnt + TMR_W'(1);
    end
  end

  assign last_c = (cnt == TMR_W'(LIMIT - 1));

endmodule

// File: rtl/arm_seq_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC sequencer: owns the PC, the fetch handshake and retire counting,
// and gates arm_decode write enables by the condition check.
module arm_seq_ctrl
  import arm_seq_ctrl_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC      = 32'h0000_0000,
  parameter int unsigned     FETCH_TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst,
  arm_seq_ctrl_if.master   imem,
  output logic [XLEN-1:0]  inst,
  input  logic             cond_pass,
  input  logic             dec_rd_we,
  input  logic             dec_pc_we,
  input  logic             dec_cpsr_we,
  input  logic [XLEN-1:0]  dec_pc_in,
  output logic             rd_we,
  output logic             cpsr_we,
  output logic [XLEN-1:0]  pc,
  input  logic             halt,
  output logic             halted,
  output logic             fault,
  output logic [XLEN-1:0]  retire_cnt
);

  seq_state_e state, state_d;
  logic       tmr_load, tmr_en, tmr_last_c;
  logic       take_branch_c;

  arm_fetch_timer #(.LIMIT(FETCH_TIMEOUT)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val ('0),
    .en       (tmr_en),
    .last_c   (tmr_last_c)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_FETCH;
    else     state <= state_d;
  end

  // Next state, timer control and the EXEC-only write-enable gating.
  always_comb begin
    state_d       = state;
    tmr_load      = 1'b0;
    tmr_en        = 1'b0;
    rd_we         = 1'b0;
    cpsr_we       = 1'b0;
    take_branch_c = 1'b0;
    case (state)
      ST_FETCH: begin
        if (imem.imem_ack) begin
          tmr_load = 1'b1;
          state_d  = ST_DECODE;
        end else begin
          tmr_en = 1'b1;
          if (tmr_last_c) state_d = ST_FAULT;
        end
      end
      ST_DECODE: state_d = ST_EXEC;
      ST_EXEC: begin
        rd_we         = dec_rd_we & cond_pass;
        cpsr_we       = dec_cpsr_we & cond_pass;
        take_branch_c = dec_pc_we & cond_pass;
        state_d       = halt ? ST_HALT : ST_FETCH;
      end
      ST_HALT:  if (!halt) state_d = ST_FETCH;
      ST_FAULT: state_d = ST_FAULT;
      default:  state_d = ST_FAULT;
    endcase
  end

  // Status flags and the request follow the state being entered, so they are clean registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      imem.imem_req <= 1'b0;
      halted        <= 1'b0;
      fault         <= 1'b0;
      inst          <= '0;
      pc            <= RESET_PC;
      retire_cnt    <= '0;
    end else begin
      imem.imem_req <= (state_d == ST_FETCH);
      halted        <= (state_d == ST_HALT);
      fault         <= (state_d == ST_FAULT);
      if (state == ST_FETCH && imem.imem_ack) inst <= imem.imem_rdata;
      if (state == ST_EXEC) begin
        retire_cnt <= retire_cnt + XLEN'(1);
        pc         <= take_branch_c ? word_align(dec_pc_in) : pc + PC_STEP;
      end
    end
  end

  assign imem.imem_addr = pc;

endmodule

// File: tb/tb_arm_seq_ctrl.sv
// Scoreboard bench for arm_seq_ctrl: expected per-instruction results are queued at fetch
// and compared once the instruction retires.
module tb_arm_seq_ctrl;

  localparam logic [31:0] RST_PC  = 32'h0000_0000;
  localparam int unsigned TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] inst, pc, retire_cnt, dec_pc_in;
  logic        cond_pass, dec_rd_we, dec_pc_we, dec_cpsr_we;
  logic        rd_we, cpsr_we, halt, halted, fault;

  arm_seq_ctrl_if bus ();

  arm_seq_ctrl #(.RESET_PC(RST_PC), .FETCH_TIMEOUT(TIMEOUT)) dut (
    .clk         (clk),
    .rst         (rst),
    .imem        (bus),
    .inst        (inst),
    .cond_pass   (cond_pass),
    .dec_rd_we   (dec_rd_we),
    .dec_pc_we   (dec_pc_we),
    .dec_cpsr_we (dec_cpsr_we),
    .dec_pc_in   (dec_pc_in),
    .rd_we       (rd_we),
    .cpsr_we     (cpsr_we),
    .pc          (pc),
    .halt        (halt),
    .halted      (halted),
    .fault       (fault),
    .retire_cnt  (retire_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] inst;
    logic        rd;
    logic        cpsr;
    logic [31:0] pc_nxt;
    logic [31:0] ret;
  } exp_t;

  exp_t        sb[$];
  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] m_pc  = RST_PC;
  logic [31:0] m_ret = 32'd0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Fetch one instruction after 'waits' idle cycles, then check DECODE, EXEC and retire.
  task automatic run_instr(input logic [31:0] rdata, input logic rdw, input logic cond,
                           input logic pcw, input logic cpw, input logic [31:0] pc_in,
                           input int waits, input logic hlt);
    exp_t e;
    int   cyc;
    bit   got;
    got = bus.imem_req;
    for (int i = 0; i < 64 && !got; i++) begin
      @(negedge clk);
      got = bus.imem_req;
    end
    if (!got) begin
      check_eq("req_wait", 32'(bus.imem_req), 32'd1);
      return;
    end
    e.addr   = m_pc;
    e.inst   = rdata;
    e.rd     = rdw & cond;
    e.cpsr   = cpw & cond;
    e.pc_nxt = (pcw & cond) ? (pc_in & 32'hFFFF_FFFC) : m_pc + 32'd4;
    e.ret    = m_ret + 32'd1;
    sb.push_back(e);
    check_eq("imem_addr", bus.imem_addr, e.addr);
    halt = hlt;
    cyc  = 0;
    bus.imem_ack = 1'b0;
    for (int i = 0; i < waits; i++) begin
      @(negedge clk);
      cyc++;
      check_eq("req_hold", 32'(bus.imem_req), 32'd1);
    end
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = rdata;
    dec_rd_we      = rdw;
    cond_pass      = cond;
    dec_pc_we      = pcw;
    dec_cpsr_we    = cpw;
    dec_pc_in      = pc_in;
    @(negedge clk);
    cyc++;
    bus.imem_ack   = 1'b0;
    bus.imem_rdata = ~rdata;
    check_eq("dec_inst", inst, sb[0].inst);
    check_eq("dec_req", 32'(bus.imem_req), 32'd0);
    check_eq("dec_rd_we", 32'(rd_we), 32'd0);
    @(negedge clk);
    cyc++;
    check_eq("exec_inst", inst, sb[0].inst);
    check_eq("exec_rd_we", 32'(rd_we), 32'(sb[0].rd));
    check_eq("exec_cpsr_we", 32'(cpsr_we), 32'(sb[0].cpsr));
    @(negedge clk);
    cyc++;
    e     = sb.pop_front();
    m_pc  = e.pc_nxt;
    m_ret = e.ret;
    check_eq("pc", pc, e.pc_nxt);
    check_eq("retire_cnt", retire_cnt, e.ret);
    check_eq("next_req", 32'(bus.imem_req), 32'(!hlt));
    check_eq("halted", 32'(halted), 32'(hlt));
    check_eq("post_rd_we", 32'(rd_we), 32'd0);
    check_eq("cycles", 32'(cyc), 32'(waits + 3));
    dec_rd_we   = 1'b0;
    dec_pc_we   = 1'b0;
    dec_cpsr_we = 1'b0;
    cond_pass   = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.imem_ack   = 1'b0;
    bus.imem_rdata = 32'h0;
    cond_pass      = 1'b0;
    dec_rd_we      = 1'b0;
    dec_pc_we      = 1'b0;
    dec_cpsr_we    = 1'b0;
    dec_pc_in      = 32'h0;
    halt           = 1'b0;

    @(negedge clk);
    check_eq("rst_req", 32'(bus.imem_req), 32'd0);
    check_eq("rst_pc", pc, RST_PC);
    check_eq("rst_addr", bus.imem_addr, RST_PC);
    check_eq("rst_inst", inst, 32'h0);
    check_eq("rst_retire", retire_cnt, 32'h0);
    check_eq("rst_flags", {29'h0, halted, fault, rd_we | cpsr_we}, 32'h0);
    rst = 1'b0;

    // Basic, failed condition, CPSR write, branch, then a wait-state fetch at the target.
    run_instr(32'hE201_1002, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0,         0, 1'b0);
    run_instr(32'hE201_1002, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0,         0, 1'b0);
    run_instr(32'hE211_1002, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0,         1, 1'b0);
    run_instr(32'hEA00_0040, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_0103, 0, 1'b0);
    check_eq("branch_addr", bus.imem_addr, 32'h0000_0100);
    run_instr(32'hE3A0_0001, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0,         5, 1'b0);
    run_instr(32'h0A00_0000, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0200, 2, 1'b0);

    // Branch to the top word, then halt while fetching it: pc wraps to 0 and parks.
    run_instr(32'hEAFF_FFFF, 1'b0, 1'b1, 1'b1, 1'b0, 32'hFFFF_FFFF, 0, 1'b0);
    check_eq("top_addr", bus.imem_addr, 32'hFFFF_FFFC);
    run_instr(32'hE1A0_0000, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0,         0, 1'b1);
    repeat (3) @(negedge clk);
    check_eq("halt_pc", pc, 32'h0);
    check_eq("halt_req", 32'(bus.imem_req), 32'd0);
    check_eq("halt_flag", 32'(halted), 32'd1);
    halt = 1'b0;
    @(negedge clk);
    check_eq("unhalt_req", 32'(bus.imem_req), 32'd1);
    check_eq("unhalt_flag", 32'(halted), 32'd0);
    run_instr(32'hE280_0004, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0,         0, 1'b0);

    // Fetch timeout: fault exactly on the TIMEOUT-th unacked FETCH edge, then sticky.
    repeat (TIMEOUT - 1) @(negedge clk);
    check_eq("pre_fault", 32'(fault), 32'd0);
    check_eq("pre_fault_req", 32'(bus.imem_req), 32'd1);
    @(negedge clk);
    check_eq("fault", 32'(fault), 32'd1);
    check_eq("fault_req", 32'(bus.imem_req), 32'd0);
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = 32'hDEAD_BEEF;
    dec_rd_we      = 1'b1;
    dec_cpsr_we    = 1'b1;
    cond_pass      = 1'b1;
    repeat (10) @(negedge clk);
    check_eq("fault_sticky", 32'(fault), 32'd1);
    check_eq("fault_inst", inst, 32'hE280_0004);
    check_eq("fault_we", 32'({rd_we, cpsr_we}), 32'd0);
    check_eq("fault_pc", pc, m_pc);
    bus.imem_ack = 1'b0;
    dec_rd_we    = 1'b0;
    dec_cpsr_we  = 1'b0;
    cond_pass    = 1'b0;

    // Reset out of FAULT, retire one, then assert reset asynchronously mid-fetch.
    rst = 1'b1;
    #1;
    check_eq("rst_fault", 32'(fault), 32'd0);
    @(negedge clk);
    rst   = 1'b0;
    m_pc  = RST_PC;
    m_ret = 32'd0;
    run_instr(32'hE201_1002, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 0, 1'b0);
    @(posedge clk);
    #2;
    check_eq("midfetch_req", 32'(bus.imem_req), 32'd1);
    rst = 1'b1;
    #1;
    check_eq("async_req", 32'(bus.imem_req), 32'd0);
    check_eq("async_pc", pc, RST_PC);
    check_eq("async_retire", retire_cnt, 32'h0);
    check_eq("async_inst", inst, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
